qea_run_sequencer: RTL and testbench
====================================

# qea_run_sequencer

Host-side run controller that sits directly upstream of the QEA core and also drains its result. It streams gate-context words into QEA context RAM, initialises QEA state RAM to |0…0⟩, pulses `start`, and counts execution cycles until `complete`. It then reads every state word back and presents it on a valid/ready output stream. It replaces the hand-written load/start/readback sequence used around QEA in simulation, and in synthesis it is the single QEA port master.

## Interface
- PE_NUM_WIDTH, 2, log2 of PE_NUM
- PE_NUM, 4, amplitudes per state word
- DATA_WIDTH, 32, real/imag component width
- STATE_DATA_WIDTH, 2*DATA_WIDTH, one complex amplitude {re,im}
- STATE_ADDR_WIDTH, 16, state RAM address width
- GATE_CONTEXT_DATA_WIDTH, 2*DATA_WIDTH, context word width
- GATE_CONTEXT_ADDR_WIDTH, 16, context RAM address width
- MAX_QBIT_WIDTH, 6, width of qubit count
- NUM_FRAC_BIT, 30, fixed-point fraction bits (1.0 = 1<<NUM_FRAC_BIT)
- RD_LATENCY, 2, QEA state-RAM read latency in cycles (≥1)
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- i_run  in  1  single-cycle run request, honoured only in IDLE
- i_qbit_num  in  MAX_QBIT_WIDTH  qubit count, latched on i_run
- i_ins_num  in  GATE_CONTEXT_ADDR_WIDTH  context words to load, latched on i_run
- i_ctx_valid / o_ctx_ready  in/out  1  context stream handshake
- i_ctx_data  in  GATE_CONTEXT_DATA_WIDTH  context word
- o_start  out  1  QEA start pulse
- o_qbit_num  out  MAX_QBIT_WIDTH  latched qubit count to QEA
- o_ctx_en, o_ctx_wea  out  1  context RAM strobes
- o_ctx_addr  out  GATE_CONTEXT_ADDR_WIDTH; o_ctx_data  out  GATE_CONTEXT_DATA_WIDTH
- o_state_ena, o_state_wea  out  PE_NUM  per-PE state RAM strobes
- o_state_addra  out  STATE_ADDR_WIDTH; o_state_dina  out  PE_NUM*STATE_DATA_WIDTH
- i_complete  in  1  QEA completion level
- i_state_dout  in  PE_NUM*STATE_DATA_WIDTH  QEA read data
- o_out_valid / i_out_ready  out/in  1  result stream handshake
- o_out_data  out  PE_NUM*STATE_DATA_WIDTH; o_out_addr  out  STATE_ADDR_WIDTH; o_out_last  out  1
- o_busy  out  1  not IDLE
- o_err  out  1  one-cycle pulse, rejected run
- o_cycles  out  32  cycles from o_start to observed completion, held until next run

## Operation
- States are IDLE → LOAD_CTX → INIT_STATE → START → WAIT → RD_ISSUE → RD_WAIT → RD_OUT → (RD_ISSUE | IDLE).
- IDLE
  - On i_run, latch i_qbit_num and i_ins_num.
  - N = 2**(qbit_num − PE_NUM_WIDTH) words.
  - qbit_num < PE_NUM_WIDTH or N > 2**STATE_ADDR_WIDTH: pulse o_err and stay IDLE.
  - i_run in any other state is ignored.
- LOAD_CTX
  - o_ctx_ready=1.
  - Each handshake drives o_ctx_en=o_ctx_wea=1, o_ctx_data=i_ctx_data, o_ctx_addr=k (k=0,1,…), registered in the following cycle.
  - Gaps in valid stall k.
  - Exit after ins_num handshakes; ins_num=0 skips the state.
- INIT_STATE
  - One word per cycle, addr 0..N−1, o_state_ena=o_state_wea=all-ones.
  - Word 0 = top PE slot {re=1<<NUM_FRAC_BIT, im=0}, all other slots 0.
  - All other words are 0.
- START: o_start=1 for exactly one cycle; clear and start o_cycles.
- WAIT
  - i_complete is ignored in the START cycle and the first WAIT cycle.
  - Thereafter, first sampled i_complete=1 freezes o_cycles and moves to RD_ISSUE.
- Readout
  - RD_ISSUE drives o_state_ena=all-ones, o_state_wea=0, addr=j for one cycle.
  - RD_WAIT waits RD_LATENCY cycles, then captures i_state_dout into the output register.
  - RD_OUT holds o_out_valid with data, addr=j, o_out_last=(j==N−1) until i_out_ready.
  - After the handshake: j==N−1 → IDLE, otherwise j+1 → RD_ISSUE.
- Counters are sized to STATE_ADDR_WIDTH+1 so N=2**STATE_ADDR_WIDTH terminates without wrap.
- o_cycles saturates at 2**32−1.

## Timing
- Reset value of every output is 0 (o_state_ena/wea, o_out_*, o_start, o_cycles, o_busy, o_err, o_ctx_*); the FSM resets to IDLE.
- Reset mid-run drops all QEA strobes within the reset assertion. No partial context or state write completes after deassertion.
- o_busy rises the cycle after an accepted i_run and falls the cycle after the last output handshake.
- Context load takes ins_num cycles with continuous valid.
- Init takes N cycles; o_start follows the last init write by exactly one cycle.
- Each readout word takes 1 + RD_LATENCY + (cycles until ready) cycles.
- All QEA-side outputs are registered.
- o_out_data is stable while o_out_valid=1 and i_out_ready=0.

## Test plan
- **Full run.** qbit_num=14, ins_num=455, continuous ctx valid, QEA model completes after 1000 cycles.
  - Required: 455 ctx writes at addr 0..454, 4096 init writes, one o_start, o_cycles=1000±1.
  - Required: 4096 outputs with addr 0..4095 and o_out_last only on 4095.
- **Init pattern.** qbit_num=3 (N=2), ins_num=0.
  - Required: no ctx writes.
  - Required: word 0 = {64'h40000000_00000000, 0, 0, 0}, word 1 = 0.
- **Ctx backpressure.** i_ctx_valid toggles 1/0.
  - Required: addresses stay contiguous, data matches the accepted words only, and the load takes 2×ins_num cycles.
- **Early/stale complete.** i_complete held high from before o_start.
  - Required: completion is not taken in the START cycle or the first WAIT cycle; o_cycles=2.
- **Output backpressure.** i_out_ready low for 5 cycles on word 1.
  - Required: data and addr are held, no word is skipped or duplicated, o_out_last appears once.
- **Error and reset.**
  - qbit_num=1 → o_err pulse, o_busy stays 0.
  - rst_n low during INIT_STATE → all outputs 0 immediately; a new i_run afterwards completes normally.

Source files
------------

// File: rtl/qea_run_sequencer.sv
// Run controller for the QEA core. It loads context RAM, initialises state RAM
// to |0..0>, starts the core, times the run and streams the final state out.
module qea_run_sequencer #(
  parameter int PE_NUM_WIDTH            = 2,
  parameter int PE_NUM                  = 4,
  parameter int DATA_WIDTH              = 32,
  parameter int STATE_DATA_WIDTH        = 2 * DATA_WIDTH,
  parameter int STATE_ADDR_WIDTH        = 16,
  parameter int GATE_CONTEXT_DATA_WIDTH = 2 * DATA_WIDTH,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int MAX_QBIT_WIDTH          = 6,
  parameter int NUM_FRAC_BIT            = 30,
  parameter int RD_LATENCY              = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_run,
  input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
  input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   i_ins_num,
  input  logic                                 i_ctx_valid,
  output logic                                 o_ctx_ready,
  input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_data,
  output logic                                 o_start,
  output logic [MAX_QBIT_WIDTH-1:0]            o_qbit_num,
  output logic                                 o_ctx_en,
  output logic                                 o_ctx_wea,
  output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
  output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_ctx_data,
  output logic [PE_NUM-1:0]                    o_state_ena,
  output logic [PE_NUM-1:0]                    o_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina,
  input  logic                                 i_complete,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_state_dout,
  output logic                                 o_out_valid,
  input  logic                                 i_out_ready,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_out_data,
  output logic [STATE_ADDR_WIDTH-1:0]          o_out_addr,
  output logic                                 o_out_last,
  output logic                                 o_busy,
  output logic                                 o_err,
  output logic [31:0]                          o_cycles
);

  localparam int CW = STATE_ADDR_WIDTH + 1;
  localparam int LW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam int SW = PE_NUM * STATE_DATA_WIDTH;
  localparam logic [MAX_QBIT_WIDTH-1:0] QBIT_MIN = MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
  localparam logic [MAX_QBIT_WIDTH-1:0] QBIT_MAX = MAX_QBIT_WIDTH'(PE_NUM_WIDTH + STATE_ADDR_WIDTH);
  localparam logic [STATE_DATA_WIDTH-1:0] AMP_ONE =
    {DATA_WIDTH'(1 << NUM_FRAC_BIT), {DATA_WIDTH{1'b0}}};
  localparam logic [SW-1:0] WORD0 = {AMP_ONE, {(SW - STATE_DATA_WIDTH){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_CTX, S_INIT_STATE, S_START, S_WAIT, S_RD_ISSUE, S_RD_WAIT, S_RD_OUT
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, last_q, last_d;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] ins_q, ins_d;
  logic [MAX_QBIT_WIDTH-1:0] qbit_d;
  logic [LW-1:0] lat_q, lat_d;
  logic armed_q, armed_d, run_bad;
  logic [31:0] cycles_d;
  logic err_d, ctx_we_d, start_d, busy_d;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] ctx_addr_d;
  logic [GATE_CONTEXT_DATA_WIDTH-1:0] ctx_data_d;
  logic [PE_NUM-1:0] state_en_d, state_we_d;
  logic [STATE_ADDR_WIDTH-1:0] state_addr_d, out_addr_d;
  logic [SW-1:0] state_din_d, out_data_d;
  logic out_valid_d, out_last_d;

  assign run_bad     = (i_qbit_num < QBIT_MIN) || (i_qbit_num > QBIT_MAX);
  assign o_ctx_ready = (state_q == S_LOAD_CTX);

  always_comb begin
    // NOTE: every variable gets a default first so no latch can be inferred.
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    ins_d      = ins_q;
    qbit_d     = o_qbit_num;
    lat_d      = lat_q;
    armed_d    = armed_q;
    cycles_d   = o_cycles;
    err_d      = 1'b0;
    ctx_we_d   = 1'b0;
    ctx_addr_d = o_ctx_addr;
    ctx_data_d = o_ctx_data;
    out_valid_d = o_out_valid;
    out_data_d  = o_out_data;
    out_addr_d  = o_out_addr;
    out_last_d  = o_out_last;

    case (state_q)
      S_IDLE: if (i_run) begin
        if (run_bad) begin
          err_d = 1'b1;
        end else begin
          qbit_d  = i_qbit_num;
          ins_d   = i_ins_num;
          last_d  = (CW'(1) << (i_qbit_num - QBIT_MIN)) - CW'(1);
          cnt_d   = '0;
          state_d = (i_ins_num == '0) ? S_INIT_STATE : S_LOAD_CTX;
        end
      end
      S_LOAD_CTX: if (i_ctx_valid) begin
        ctx_we_d   = 1'b1;
        ctx_addr_d = GATE_CONTEXT_ADDR_WIDTH'(cnt_q);
        ctx_data_d = i_ctx_data;
        if (cnt_q + CW'(1) == CW'(ins_q)) begin
          cnt_d   = '0;
          state_d = S_INIT_STATE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_INIT_STATE: begin
        if (cnt_q == last_q) begin
          state_d  = S_START;
          cycles_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_START: begin
        cycles_d = 32'd1;
        armed_d  = 1'b0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        // Completion is only trusted from the second WAIT cycle on, so a level
        // left over from a previous run cannot end this one.
        if (armed_q && i_complete) begin
          cnt_d   = '0;
          state_d = S_RD_ISSUE;
        end else begin
          armed_d = 1'b1;
          if (o_cycles != '1) cycles_d = o_cycles + 32'd1;
        end
      end
      S_RD_ISSUE: begin
        lat_d   = '0;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (lat_q == LW'(RD_LATENCY - 1)) begin
          out_valid_d = 1'b1;
          out_data_d  = i_state_dout;
          out_addr_d  = STATE_ADDR_WIDTH'(cnt_q);
          out_last_d  = (cnt_q == last_q);
          state_d     = S_RD_OUT;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      S_RD_OUT: if (i_out_ready) begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        if (cnt_q == last_q) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = S_RD_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // QEA strobes decode the next state so they are flops aligned with it.
    state_en_d   = (state_d == S_INIT_STATE || state_d == S_RD_ISSUE) ? '1 : '0;
    state_we_d   = (state_d == S_INIT_STATE) ? '1 : '0;
    state_addr_d = (state_en_d != '0) ? STATE_ADDR_WIDTH'(cnt_d) : '0;
    state_din_d  = (state_d == S_INIT_STATE && cnt_d == '0) ? WORD0 : '0;
    start_d      = (state_d == S_START);
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      last_q        <= '0;
      ins_q         <= '0;
      lat_q         <= '0;
      armed_q       <= 1'b0;
      o_qbit_num    <= '0;
      o_cycles      <= '0;
      o_err         <= 1'b0;
      o_busy        <= 1'b0;
      o_start       <= 1'b0;
      o_ctx_en      <= 1'b0;
      o_ctx_wea     <= 1'b0;
      o_ctx_addr    <= '0;
      o_ctx_data    <= '0;
      o_state_ena   <= '0;
      o_state_wea   <= '0;
      o_state_addra <= '0;
      o_state_dina  <= '0;
      o_out_valid   <= 1'b0;
      o_out_data    <= '0;
      o_out_addr    <= '0;
      o_out_last    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_q        <= last_d;
      ins_q         <= ins_d;
      lat_q         <= lat_d;
      armed_q       <= armed_d;
      o_qbit_num    <= qbit_d;
      o_cycles      <= cycles_d;
      o_err         <= err_d;
      o_busy        <= busy_d;
      o_start       <= start_d;
      o_ctx_en      <= ctx_we_d;
      o_ctx_wea     <= ctx_we_d;
      o_ctx_addr    <= ctx_addr_d;
      o_ctx_data    <= ctx_data_d;
      o_state_ena   <= state_en_d;
      o_state_wea   <= state_we_d;
      o_state_addra <= state_addr_d;
      o_state_dina  <= state_din_d;
      o_out_valid   <= out_valid_d;
      o_out_data    <= out_data_d;
      o_out_addr    <= out_addr_d;
      o_out_last    <= out_last_d;
    end
  end

endmodule

// File: tb/tb_qea_run_sequencer.sv
// Scoreboard bench for qea_run_sequencer: stimulus queues expected QEA-side and
// stream-side events, independent monitors pop and compare them.
module tb_qea_run_sequencer;

  localparam int SW = 256;
  localparam int RD_LATENCY = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            i_run = 1'b0;
  logic [5:0]      i_qbit_num = '0;
  logic [15:0]     i_ins_num = '0;
  logic            i_ctx_valid = 1'b0;
  logic            o_ctx_ready;
  logic [63:0]     i_ctx_data = '0;
  logic            o_start;
  logic [5:0]      o_qbit_num;
  logic            o_ctx_en, o_ctx_wea;
  logic [15:0]     o_ctx_addr;
  logic [63:0]     o_ctx_data;
  logic [3:0]      o_state_ena, o_state_wea;
  logic [15:0]     o_state_addra;
  logic [SW-1:0]   o_state_dina;
  logic            i_complete;
  logic [SW-1:0]   i_state_dout;
  logic            o_out_valid;
  logic            i_out_ready = 1'b1;
  logic [SW-1:0]   o_out_data;
  logic [15:0]     o_out_addr;
  logic            o_out_last, o_busy, o_err;
  logic [31:0]     o_cycles;

  always #5 clk = ~clk;

  qea_run_sequencer dut (
    .clk(clk), .rst_n(rst_n), .i_run(i_run), .i_qbit_num(i_qbit_num), .i_ins_num(i_ins_num),
    .i_ctx_valid(i_ctx_valid), .o_ctx_ready(o_ctx_ready), .i_ctx_data(i_ctx_data),
    .o_start(o_start), .o_qbit_num(o_qbit_num), .o_ctx_en(o_ctx_en), .o_ctx_wea(o_ctx_wea),
    .o_ctx_addr(o_ctx_addr), .o_ctx_data(o_ctx_data), .o_state_ena(o_state_ena),
    .o_state_wea(o_state_wea), .o_state_addra(o_state_addra), .o_state_dina(o_state_dina),
    .i_complete(i_complete), .i_state_dout(i_state_dout), .o_out_valid(o_out_valid),
    .i_out_ready(i_out_ready), .o_out_data(o_out_data), .o_out_addr(o_out_addr),
    .o_out_last(o_out_last), .o_busy(o_busy), .o_err(o_err), .o_cycles(o_cycles)
  );

  typedef struct packed { logic [15:0] addr; logic [63:0] data; } ctx_t;
  typedef struct packed { logic [15:0] addr; logic [SW-1:0] data; } st_t;
  typedef struct packed { logic [15:0] addr; logic [SW-1:0] data; logic last; } out_t;

  ctx_t ctx_q[$];
  st_t  init_q[$];
  out_t out_q[$];
  int   load_q[$];
  int   start_q[$];
  int   cyc_q[$];

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ctx_word(input int k, input int seed);
    return {32'(k) ^ 32'h1234_5678, 32'(k * 5 + seed)};
  endfunction

  function automatic logic [SW-1:0] pat(input int a, input int seed);
    logic [31:0] x;
    x = 32'(a);
    return {x, 32'(seed), x ^ 32'h5A5A_5A5A, ~x, x * 32'd7, x + 32'(seed), 32'hDEAD_0000 | x, ~32'(seed)};
  endfunction

  // QEA model: state RAM with RD_LATENCY read pipe; o_start overwrites the RAM
  // with a run-specific pattern and completion rises complete_delay cycles later.
  logic [SW-1:0] mem [0:4095];
  logic [SW-1:0] rd_pipe [0:RD_LATENCY-1];
  int run_cnt = 0;
  bit running = 1'b0;
  int complete_delay = 10;
  bit complete_hold = 1'b0;
  int run_seed = 0;
  int bp_left = 0;

  assign i_state_dout = rd_pipe[RD_LATENCY-1];
  assign i_complete   = complete_hold | (running && run_cnt >= complete_delay);

  always @(posedge clk) begin
    if (o_state_ena != 4'h0 && o_state_wea != 4'h0) mem[o_state_addra[11:0]] <= o_state_dina;
    if (o_start) for (int i = 0; i < 4096; i++) mem[i] <= pat(i, run_seed);
    if (o_state_ena != 4'h0 && o_state_wea == 4'h0) rd_pipe[0] <= mem[o_state_addra[11:0]];
    for (int i = 1; i < RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (o_start) begin
      running <= 1'b1;
      run_cnt <= 1;
    end else if (!o_busy) begin
      running <= 1'b0;
    end else if (running) begin
      run_cnt <= run_cnt + 1;
    end
  end

  // Output-side ready: optionally stall word 1 for bp_left cycles.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_left > 0 && o_out_valid && o_out_addr == 16'd1) begin
        i_out_ready = 1'b0;
        bp_left--;
      end else begin
        i_out_ready = 1'b1;
      end
    end
  end

  // Monitors, all sampled on the falling edge.
  logic        prev_wr = 1'b0;
  logic [15:0] prev_wr_addr = '0;
  logic        prev_rdy = 1'b0;
  int          ld_cnt = 0;
  logic        hold_v = 1'b0;
  logic [SW-1:0] hold_data = '0;
  logic [15:0] hold_addr = '0;

  always @(negedge clk) begin
    ctx_t c;
    if (o_ctx_en) begin
      if (ctx_q.size() == 0) check("ctx_extra_write", 256'(o_ctx_en), 256'(0));
      else begin
        c = ctx_q.pop_front();
        check("ctx_addr", 256'(o_ctx_addr), 256'(c.addr));
        check("ctx_data", 256'(o_ctx_data), 256'(c.data));
        check("ctx_wea", 256'(o_ctx_wea), 256'(1));
      end
    end
  end

  always @(negedge clk) begin
    st_t s;
    int e;
    if (o_state_wea != 4'h0) begin
      if (init_q.size() == 0) check("init_extra_write", 256'(o_state_wea), 256'(0));
      else begin
        s = init_q.pop_front();
        check("init_ena", 256'(o_state_ena), 256'(4'hF));
        check("init_wea", 256'(o_state_wea), 256'(4'hF));
        check("init_addr", 256'(o_state_addra), 256'(s.addr));
        check("init_data", o_state_dina, s.data);
      end
    end
    if (o_start) begin
      if (start_q.size() == 0) check("start_extra", 256'(o_start), 256'(0));
      else begin
        e = start_q.pop_front();
        check("start_after_last_init", 256'({prev_wr, prev_wr_addr}), 256'({1'b1, 16'(e)}));
      end
    end
    prev_wr      <= (o_state_wea != 4'h0);
    prev_wr_addr <= o_state_addra;
  end

  always @(negedge clk) begin
    int e;
    if (prev_rdy && !o_ctx_ready) begin
      if (load_q.size() == 0) check("load_extra", 256'(prev_rdy), 256'(0));
      else begin
        e = load_q.pop_front();
        check("load_cycles", 256'(ld_cnt), 256'(e));
      end
    end
    prev_rdy <= o_ctx_ready;
    ld_cnt   <= i_run ? 0 : (o_ctx_ready ? ld_cnt + 1 : ld_cnt);
  end

  always @(negedge clk) begin
    out_t o;
    int e;
    if (o_out_valid && hold_v) begin
      check("out_hold_data", o_out_data, hold_data);
      check("out_hold_addr", 256'(o_out_addr), 256'(hold_addr));
    end
    if (o_out_valid && i_out_ready) begin
      if (out_q.size() == 0) check("out_extra", 256'(o_out_valid), 256'(0));
      else begin
        o = out_q.pop_front();
        check("out_addr", 256'(o_out_addr), 256'(o.addr));
        check("out_data", o_out_data, o.data);
        check("out_last", 256'(o_out_last), 256'(o.last));
        if (o.last && cyc_q.size() != 0) begin
          e = cyc_q.pop_front();
          check("cycles", 256'(o_cycles), 256'(e));
        end
      end
    end
    hold_v    <= o_out_valid && !i_out_ready;
    hold_data <= o_out_data;
    hold_addr <= o_out_addr;
  end

  task automatic push_expect(input int qbit, input int ins, input bit gap, input int exp_cyc,
                             input int seed);
    int n;
    n = 1 << (qbit - 2);
    for (int k = 0; k < ins; k++) ctx_q.push_back({16'(k), ctx_word(k, seed)});
    if (ins > 0) load_q.push_back(gap ? 2 * ins : ins);
    for (int a = 0; a < n; a++)
      init_q.push_back({16'(a), (a == 0) ? {64'h4000_0000_0000_0000, 192'd0} : 256'd0});
    start_q.push_back(n - 1);
    cyc_q.push_back(exp_cyc);
    for (int a = 0; a < n; a++) out_q.push_back({16'(a), pat(a, seed), a == n - 1});
  endtask

  task automatic pulse_run(input int qbit, input int ins);
    @(posedge clk);
    #1;
    i_qbit_num = 6'(qbit);
    i_ins_num  = 16'(ins);
    i_run      = 1'b1;
    @(posedge clk);
    #1;
    i_run = 1'b0;
  endtask

  task automatic run_test(input int qbit, input int ins, input bit gap, input int delay,
                          input bit hold, input int exp_cyc, input int seed);
    int k;
    int guard;
    bit ph;
    bit hs;
    run_seed = seed;
    complete_delay = delay;
    complete_hold = hold;
    push_expect(qbit, ins, gap, exp_cyc, seed);
    pulse_run(qbit, ins);
    check("busy_rise", 256'(o_busy), 256'(1));
    check("qbit_latched", 256'(o_qbit_num), 256'(qbit));
    k = 0;
    guard = 0;
    ph = 1'b0;
    while (k < ins && guard < 20000) begin
      if (o_ctx_ready) begin
        i_ctx_valid = gap ? ph : 1'b1;
        ph = !ph;
      end else begin
        i_ctx_valid = 1'b0;
      end
      i_ctx_data = ctx_word(k, seed);
      @(negedge clk);
      hs = i_ctx_valid && o_ctx_ready;
      @(posedge clk);
      #1;
      if (hs) k++;
      guard++;
    end
    i_ctx_valid = 1'b0;
    guard = 0;
    while (o_busy && guard < 40000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("run_finished", 256'(o_busy), 256'(0));
    complete_hold = 1'b0;
    check("ctx_q_drained", 256'(ctx_q.size()), 256'(0));
    check("init_q_drained", 256'(init_q.size()), 256'(0));
    check("out_q_drained", 256'(out_q.size()), 256'(0));
    check("start_q_drained", 256'(start_q.size()), 256'(0));
  endtask

  initial begin
    int guard;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 256'(o_busy), 256'(0));
    check("rst_start", 256'(o_start), 256'(0));
    check("rst_state_ena", 256'(o_state_ena), 256'(0));
    check("rst_ctx_ready", 256'(o_ctx_ready), 256'(0));
    check("rst_out_valid", 256'(o_out_valid), 256'(0));
    check("rst_cycles", 256'(o_cycles), 256'(0));
    rst_n = 1'b1;

    // Rejected runs: too few qubits, and more words than the address space.
    pulse_run(1, 3);
    check("err_pulse_q1", 256'(o_err), 256'(1));
    check("err_busy_q1", 256'(o_busy), 256'(0));
    @(posedge clk);
    #1;
    check("err_clear_q1", 256'(o_err), 256'(0));
    check("err_idle_q1", 256'(o_busy), 256'(0));
    pulse_run(19, 0);
    check("err_pulse_q19", 256'(o_err), 256'(1));
    check("err_busy_q19", 256'(o_busy), 256'(0));

    run_test(3, 0, 1'b0, 5, 1'b0, 5, 11);      // init pattern, no context
    run_test(4, 6, 1'b1, 10, 1'b0, 10, 22);    // ctx valid toggling
    run_test(3, 2, 1'b0, 100, 1'b1, 2, 33);    // stale completion level
    bp_left = 5;
    run_test(4, 1, 1'b0, 7, 1'b0, 7, 44);      // output backpressure on word 1
    check("bp_consumed", 256'(bp_left), 256'(0));

    // Reset in the middle of state initialisation.
    push_expect(10, 0, 1'b0, 0, 55);
    pulse_run(10, 0);
    guard = 0;
    while (!(o_state_wea != 4'h0 && o_state_addra >= 16'd20) && guard < 2000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("reached_init", 256'(o_state_wea), 256'(4'hF));
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_state_ena", 256'(o_state_ena), 256'(0));
    check("midrst_state_wea", 256'(o_state_wea), 256'(0));
    check("midrst_addr", 256'(o_state_addra), 256'(0));
    check("midrst_dina", o_state_dina, 256'(0));
    check("midrst_busy", 256'(o_busy), 256'(0));
    check("midrst_ctx_en", 256'(o_ctx_en), 256'(0));
    ctx_q.delete();
    init_q.delete();
    out_q.delete();
    start_q.delete();
    cyc_q.delete();
    load_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_test(5, 3, 1'b0, 9, 1'b0, 9, 66);      // clean run after reset

    run_test(14, 455, 1'b0, 1000, 1'b0, 1000, 77);  // full-size run

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
